// File: rtl/order_book_pkg.sv
// Shared types for the order book engine.
//   op_t     : command opcodes as ASCII bytes from the feed parser
//   status_t : response status codes
//   state_t  : engine FSM states
//   slot_t   : one order slot; fields are sized to the widest supported
//              configuration, and narrower instances zero-extend into them
package order_book_pkg;

    localparam int unsigned SLOT_ID_W    = 64;
    localparam int unsigned SLOT_PRICE_W = 32;
    localparam int unsigned SLOT_QTY_W   = 32;

    typedef enum logic [7:0] {
        OP_ADD = 8'h41,
        OP_MOD = 8'h55,
        OP_DEL = 8'h44
    } op_t;

    typedef enum logic [2:0] {
        STAT_OK        = 3'd0,
        STAT_FULL      = 3'd1,
        STAT_NOT_FOUND = 3'd2,
        STAT_DUP_ID    = 3'd3,
        STAT_BAD_STOCK = 3'd4,
        STAT_BAD_OP    = 3'd5
    } status_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_COMMIT,
        S_SCAN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic                    vld;
        logic                    side;   // 0 bid, 1 ask
        logic [SLOT_ID_W-1:0]    ref_id;
        logic [SLOT_PRICE_W-1:0] price;
        logic [SLOT_QTY_W-1:0]   qty;
    } slot_t;

    function automatic logic is_known_op(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_MOD) || (op == OP_DEL);
    endfunction

endpackage

// File: rtl/order_book_if.sv
// Order book engine bus: command stream from the feed parser plus the
// response pulse and per-stock best prices towards the trading logic.
//   master : feed/trading side (drives in_*, observes everything else)
//   slave  : engine side
interface order_book_if #(
    parameter int unsigned N_STOCKS = 4,
    parameter int unsigned PRICE_W  = 32,
    parameter int unsigned QTY_W    = 32,
    parameter int unsigned ID_W     = 64
);
    localparam int unsigned STOCK_W = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1;

    logic                         in_valid;
    logic                         in_ready;
    logic [7:0]                   in_op;
    logic                         in_side;
    logic [STOCK_W-1:0]           in_stock;
    logic [ID_W-1:0]              in_ref_id;
    logic [PRICE_W-1:0]           in_price;
    logic [QTY_W-1:0]             in_qty;
    logic                         rsp_valid;
    logic [2:0]                   rsp_status;
    logic [N_STOCKS*PRICE_W-1:0]  best_bid_price;
    logic [N_STOCKS*PRICE_W-1:0]  best_ask_price;
    logic [N_STOCKS-1:0]          best_bid_vld;
    logic [N_STOCKS-1:0]          best_ask_vld;

    modport master (
        output in_valid, in_op, in_side, in_stock, in_ref_id, in_price, in_qty,
        input  in_ready, rsp_valid, rsp_status,
               best_bid_price, best_ask_price, best_bid_vld, best_ask_vld
    );

    modport slave (
        input  in_valid, in_op, in_side, in_stock, in_ref_id, in_price, in_qty,
        output in_ready, rsp_valid, rsp_status,
               best_bid_price, best_ask_price, best_bid_vld, best_ask_vld
    );

endinterface

// File: rtl/order_book_best_price_scan.sv
// Sequential best-price accumulator: max over valid bid slots, min over
// valid ask slots, one slot per step.
//   clk, reset_n        : clock, async active-low reset
//   start               : clear the accumulators
//   step                : present slot is part of the scan
//   slot_vld/side/price : slot being visited
//   best_bid/best_ask   : result, 0 when no slot of that side was seen
//   bid_vld/ask_vld     : at least one slot of that side was seen
// Results already include the slot presented this cycle, so they are
// final during the last step.
module best_price_scan #(
    parameter int unsigned PRICE_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               step,
    input  logic               slot_vld,
    input  logic               slot_side,
    input  logic [PRICE_W-1:0] slot_price,
    output logic [PRICE_W-1:0] best_bid,
    output logic [PRICE_W-1:0] best_ask,
    output logic               bid_vld,
    output logic               ask_vld
);

    logic [PRICE_W-1:0] bid_q, bid_d, ask_q, ask_d;
    logic               bid_f_q, bid_f_d, ask_f_q, ask_f_d;

    always_comb begin
        bid_d   = bid_q;
        ask_d   = ask_q;
        bid_f_d = bid_f_q;
        ask_f_d = ask_f_q;
        if (step && slot_vld) begin
            if (!slot_side) begin
                if (!bid_f_q || (slot_price > bid_q)) begin
                    bid_d = slot_price;
                end
                bid_f_d = 1'b1;
            end else begin
                if (!ask_f_q || (slot_price < ask_q)) begin
                    ask_d = slot_price;
                end
                ask_f_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bid_q   <= '0;
            ask_q   <= '0;
            bid_f_q <= 1'b0;
            ask_f_q <= 1'b0;
        end else if (start) begin
            bid_q   <= '0;
            ask_q   <= '0;
            bid_f_q <= 1'b0;
            ask_f_q <= 1'b0;
        end else if (step) begin
            bid_q   <= bid_d;
            ask_q   <= ask_d;
            bid_f_q <= bid_f_d;
            ask_f_q <= ask_f_d;
        end
    end

    assign best_bid = bid_f_d ? bid_d : '0;
    assign best_ask = ask_f_d ? ask_d : '0;
    assign bid_vld  = bid_f_d;
    assign ask_vld  = ask_f_d;

endmodule

// File: rtl/order_book_engine.sv
// Multi-stock limit order book: add / modify / delete by reference ID,
// with best bid / best ask per stock recomputed by a slot scan after
// every successful command.
//   clk, reset_n : clock, async active-low reset
//   bus          : order_book_if.slave (command stream, response, best prices)
module order_book_engine
    import order_book_pkg::*;
#(
    parameter int unsigned N_STOCKS = 4,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned PRICE_W  = 32,
    parameter int unsigned QTY_W    = 32,
    parameter int unsigned ID_W     = 64
) (
    input logic          clk,
    input logic          reset_n,
    order_book_if.slave  bus
);

    localparam int unsigned STOCK_W = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1;
    localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t              state_q, state_d;
    logic                in_ready_d, rsp_valid_d;

    logic [7:0]          op_q;
    logic                side_q;
    logic [STOCK_W-1:0]  stock_q;
    logic [ID_W-1:0]     id_q;
    logic [PRICE_W-1:0]  price_q;
    logic [QTY_W-1:0]    qty_q;
    status_t             status_q;
    logic [IDX_W-1:0]    slot_idx_q;
    logic [IDX_W-1:0]    scan_idx_q;

    slot_t               book_q [N_STOCKS][DEPTH];
    logic [N_STOCKS-1:0][PRICE_W-1:0] best_bid_q, best_ask_q;
    logic [N_STOCKS-1:0] bid_vld_q, ask_vld_q;

    logic                stock_ok;
    logic [STOCK_W-1:0]  stock_sel;
    logic                hit, free_found;
    logic [IDX_W-1:0]    hit_idx, free_idx;
    status_t             lookup_status;
    logic                scan_last;
    slot_t               cur_slot;
    logic [PRICE_W-1:0]  scan_bid, scan_ask;
    logic                scan_bid_vld, scan_ask_vld;

    // Out-of-range stock indices never address the table.
    assign stock_ok  = 32'(stock_q) < N_STOCKS;
    assign stock_sel = stock_ok ? stock_q : '0;
    assign scan_last = scan_idx_q == IDX_W'(DEPTH - 1);
    assign cur_slot  = book_q[stock_q][scan_idx_q];

    // Parallel ref_id match and lowest free slot over the selected stock.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (book_q[stock_sel][i].vld) begin
                if (!hit && (book_q[stock_sel][i].ref_id == SLOT_ID_W'(id_q))) begin
                    hit     = 1'b1;
                    hit_idx = IDX_W'(i);
                end
            end else if (!free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        lookup_status = STAT_OK;
        if (!stock_ok) begin
            lookup_status = STAT_BAD_STOCK;
        end else if (!is_known_op(op_q)) begin
            lookup_status = STAT_BAD_OP;
        end else if (op_q == OP_ADD) begin
            if (hit) begin
                lookup_status = STAT_DUP_ID;
            end else if (!free_found) begin
                lookup_status = STAT_FULL;
            end
        end else if (!hit) begin
            lookup_status = STAT_NOT_FOUND;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_d  = 1'b0;
        rsp_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready_d = 1'b1;
                if (bus.in_valid) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: state_d = (lookup_status == STAT_OK) ? S_COMMIT : S_DONE;
            S_COMMIT: state_d = S_SCAN;
            S_SCAN:   state_d = scan_last ? S_DONE : S_SCAN;
            S_DONE: begin
                rsp_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q       <= '0;
            side_q     <= 1'b0;
            stock_q    <= '0;
            id_q       <= '0;
            price_q    <= '0;
            qty_q      <= '0;
            status_q   <= STAT_OK;
            slot_idx_q <= '0;
            scan_idx_q <= '0;
            best_bid_q <= '0;
            best_ask_q <= '0;
            bid_vld_q  <= '0;
            ask_vld_q  <= '0;
            for (int unsigned s = 0; s < N_STOCKS; s++) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    book_q[s][i] <= '0;
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_q    <= bus.in_op;
                        side_q  <= bus.in_side;
                        stock_q <= bus.in_stock;
                        id_q    <= bus.in_ref_id;
                        price_q <= bus.in_price;
                        qty_q   <= bus.in_qty;
                    end
                end
                S_LOOKUP: begin
                    status_q   <= lookup_status;
                    slot_idx_q <= (op_q == OP_ADD) ? free_idx : hit_idx;
                end
                S_COMMIT: begin
                    scan_idx_q <= '0;
                    if (op_q == OP_ADD) begin
                        book_q[stock_q][slot_idx_q] <= '{vld:    1'b1,
                                                         side:   side_q,
                                                         ref_id: SLOT_ID_W'(id_q),
                                                         price:  SLOT_PRICE_W'(price_q),
                                                         qty:    SLOT_QTY_W'(qty_q)};
                    end else if ((op_q == OP_DEL) || (qty_q == '0)) begin
                        book_q[stock_q][slot_idx_q].vld <= 1'b0;
                    end else begin
                        book_q[stock_q][slot_idx_q].price <= SLOT_PRICE_W'(price_q);
                        book_q[stock_q][slot_idx_q].qty   <= SLOT_QTY_W'(qty_q);
                    end
                end
                S_SCAN: begin
                    scan_idx_q <= scan_idx_q + 1'b1;
                    // Loading on the last scan edge makes the new best
                    // visible in the DONE cycle alongside rsp_valid.
                    if (scan_last) begin
                        for (int unsigned s = 0; s < N_STOCKS; s++) begin
                            if (STOCK_W'(s) == stock_q) begin
                                best_bid_q[s] <= scan_bid;
                                best_ask_q[s] <= scan_ask;
                                bid_vld_q[s]  <= scan_bid_vld;
                                ask_vld_q[s]  <= scan_ask_vld;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    best_price_scan #(
        .PRICE_W (PRICE_W)
    ) u_scan (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (state_q == S_COMMIT),
        .step       (state_q == S_SCAN),
        .slot_vld   (cur_slot.vld),
        .slot_side  (cur_slot.side),
        .slot_price (cur_slot.price[PRICE_W-1:0]),
        .best_bid   (scan_bid),
        .best_ask   (scan_ask),
        .bid_vld    (scan_bid_vld),
        .ask_vld    (scan_ask_vld)
    );

    assign bus.in_ready       = in_ready_d;
    assign bus.rsp_valid      = rsp_valid_d;
    assign bus.rsp_status     = status_q;
    assign bus.best_bid_price = best_bid_q;
    assign bus.best_ask_price = best_ask_q;
    assign bus.best_bid_vld   = bid_vld_q;
    assign bus.best_ask_vld   = ask_vld_q;

endmodule

// File: tb/tb_order_book_engine.sv
module tb_order_book_engine;
    import order_book_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    order_book_if #(.N_STOCKS(2), .PRICE_W(32), .QTY_W(32), .ID_W(64)) bus ();
    order_book_if #(.N_STOCKS(3), .PRICE_W(32), .QTY_W(32), .ID_W(64)) bus3 ();

    order_book_engine #(
        .N_STOCKS (2), .DEPTH (4), .PRICE_W (32), .QTY_W (32), .ID_W (64)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    order_book_engine #(
        .N_STOCKS (3), .DEPTH (2), .PRICE_W (32), .QTY_W (32), .ID_W (64)
    ) dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus3.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic book(input string tag, input int s,
                        input logic [31:0] bb, input logic bv,
                        input logic [31:0] ab, input logic av);
        chk({tag, "/bid"},     bus.best_bid_price[s*32 +: 32], bb);
        chk({tag, "/bid_vld"}, bus.best_bid_vld[s],            bv);
        chk({tag, "/ask"},     bus.best_ask_price[s*32 +: 32], ab);
        chk({tag, "/ask_vld"}, bus.best_ask_vld[s],            av);
    endtask

    // Issue one command and wait (bounded) for its response; checks the
    // response latency in cycles after acceptance and the status.
    task automatic cmd(input int which, input logic [7:0] op, input logic side,
                       input logic [1:0] stock, input logic [63:0] id,
                       input logic [31:0] price, input logic [31:0] qty,
                       input logic [2:0] exp_st, input int exp_lat, input string tag);
        int         lat = 0;
        logic [2:0] st  = '0;
        @(negedge clk);
        if (which == 0) begin
            bus.in_valid = 1'b1;  bus.in_op = op;  bus.in_side = side;
            bus.in_stock = stock[0];  bus.in_ref_id = id;
            bus.in_price = price;  bus.in_qty = qty;
        end else begin
            bus3.in_valid = 1'b1;  bus3.in_op = op;  bus3.in_side = side;
            bus3.in_stock = stock;  bus3.in_ref_id = id;
            bus3.in_price = price;  bus3.in_qty = qty;
        end
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.in_valid  = 1'b0;
                bus3.in_valid = 1'b0;
            end
            if ((which == 0) ? bus.rsp_valid : bus3.rsp_valid) begin
                lat = k;
                st  = (which == 0) ? bus.rsp_status : bus3.rsp_status;
                break;
            end
        end
        chk({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "/status"},  64'(st),  64'(exp_st));
    endtask

    initial begin
        logic saw_rsp;
        bus.in_valid = 1'b0;  bus.in_op = '0;  bus.in_side = 1'b0;  bus.in_stock = '0;
        bus.in_ref_id = '0;   bus.in_price = '0;  bus.in_qty = '0;
        bus3.in_valid = 1'b0; bus3.in_op = '0; bus3.in_side = 1'b0; bus3.in_stock = '0;
        bus3.in_ref_id = '0;  bus3.in_price = '0; bus3.in_qty = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst/in_ready",   bus.in_ready, 1'b1);
        chk("rst/rsp_valid",  bus.rsp_valid, 1'b0);
        chk("rst/rsp_status", bus.rsp_status, STAT_OK);
        chk("rst/bid_all",    bus.best_bid_price, '0);
        chk("rst/ask_all",    bus.best_ask_price, '0);
        chk("rst/vld_all",    {bus.best_bid_vld, bus.best_ask_vld}, '0);

        // First add: OK at T+7
        cmd(0, OP_ADD, 1'b0, 0, 64'd1, 32'd100, 32'd10, STAT_OK, 7, "add1");
        book("add1/s0", 0, 32'd100, 1'b1, 32'd0, 1'b0);
        book("add1/s1", 1, 32'd0,   1'b0, 32'd0, 1'b0);

        // Several bids and an ask, then deletes
        cmd(0, OP_ADD, 1'b0, 0, 64'd2, 32'd105, 32'd1, STAT_OK, 7, "add2");
        cmd(0, OP_ADD, 1'b0, 0, 64'd3, 32'd95,  32'd1, STAT_OK, 7, "add3");
        cmd(0, OP_ADD, 1'b1, 0, 64'd4, 32'd110, 32'd1, STAT_OK, 7, "add4");
        book("s0_4", 0, 32'd105, 1'b1, 32'd110, 1'b1);
        cmd(0, OP_DEL, 1'b0, 0, 64'd2, 32'd0, 32'd0, STAT_OK, 7, "del2");
        book("del2", 0, 32'd100, 1'b1, 32'd110, 1'b1);
        cmd(0, OP_DEL, 1'b0, 0, 64'd4, 32'd0, 32'd0, STAT_OK, 7, "del4");
        book("del4", 0, 32'd100, 1'b1, 32'd0, 1'b0);

        // Fill stock1, overflow, free one slot and refill
        cmd(0, OP_ADD, 1'b0, 1, 64'd10, 32'd50, 32'd1, STAT_OK, 7, "f10");
        cmd(0, OP_ADD, 1'b1, 1, 64'd11, 32'd60, 32'd1, STAT_OK, 7, "f11");
        cmd(0, OP_ADD, 1'b1, 1, 64'd12, 32'd55, 32'd1, STAT_OK, 7, "f12");
        cmd(0, OP_ADD, 1'b0, 1, 64'd13, 32'd52, 32'd1, STAT_OK, 7, "f13");
        book("fill", 1, 32'd52, 1'b1, 32'd55, 1'b1);
        cmd(0, OP_ADD, 1'b0, 1, 64'd14, 32'd70, 32'd1, STAT_FULL, 2, "full");
        book("full", 1, 32'd52, 1'b1, 32'd55, 1'b1);
        cmd(0, OP_DEL, 1'b0, 1, 64'd14, 32'd0, 32'd0, STAT_NOT_FOUND, 2, "full_noentry");
        cmd(0, OP_DEL, 1'b0, 1, 64'd12, 32'd0, 32'd0, STAT_OK, 7, "del12");
        book("del12", 1, 32'd52, 1'b1, 32'd60, 1'b1);
        cmd(0, OP_ADD, 1'b1, 1, 64'd15, 32'd58, 32'd1, STAT_OK, 7, "readd");
        book("readd", 1, 32'd58 - 32'd6, 1'b1, 32'd58, 1'b1);
        cmd(0, OP_ADD, 1'b0, 1, 64'd16, 32'd1, 32'd1, STAT_FULL, 2, "full2");

        // Error statuses
        cmd(0, OP_ADD, 1'b0, 0, 64'd3,  32'd1, 32'd1, STAT_DUP_ID,    2, "dup");
        cmd(0, OP_MOD, 1'b0, 0, 64'd99, 32'd1, 32'd1, STAT_NOT_FOUND, 2, "mod_unk");
        cmd(0, OP_DEL, 1'b0, 0, 64'd99, 32'd0, 32'd0, STAT_NOT_FOUND, 2, "del_unk");
        cmd(0, OP_DEL, 1'b0, 0, 64'd10, 32'd0, 32'd0, STAT_NOT_FOUND, 2, "del_otherstock");
        cmd(0, 8'h58,  1'b0, 0, 64'd1,  32'd1, 32'd1, STAT_BAD_OP,    2, "badop");
        book("errs", 0, 32'd100, 1'b1, 32'd0, 1'b0);
        cmd(1, OP_ADD, 1'b0, 3, 64'd1, 32'd9, 32'd1, STAT_BAD_STOCK, 2, "badstock");
        cmd(1, 8'h58,  1'b0, 3, 64'd1, 32'd9, 32'd1, STAT_BAD_STOCK, 2, "badstock_first");
        cmd(1, OP_ADD, 1'b1, 2, 64'd1, 32'd9, 32'd1, STAT_OK, 5, "laststock");
        chk("laststock/ask", bus3.best_ask_price[64 +: 32], 32'd9);
        chk("laststock/vld", {bus3.best_ask_vld, bus3.best_bid_vld}, 6'b100_000);

        // Modify: price change, qty=0 removal, side preserved
        cmd(0, OP_MOD, 1'b1, 0, 64'd1, 32'd120, 32'd5, STAT_OK, 7, "mod1");
        book("mod1", 0, 32'd120, 1'b1, 32'd0, 1'b0);
        cmd(0, OP_MOD, 1'b0, 0, 64'd1, 32'd120, 32'd0, STAT_OK, 7, "mod1_zero");
        book("mod1_zero", 0, 32'd95, 1'b1, 32'd0, 1'b0);
        cmd(0, OP_DEL, 1'b0, 0, 64'd1, 32'd0, 32'd0, STAT_NOT_FOUND, 2, "mod1_gone");
        cmd(0, OP_MOD, 1'b0, 0, 64'd3, 32'd95, 32'd0, STAT_OK, 7, "mod3_zero");
        book("mod3_zero", 0, 32'd0, 1'b0, 32'd0, 1'b0);
        cmd(0, OP_MOD, 1'b1, 1, 64'd13, 32'd200, 32'd1, STAT_OK, 7, "mod13");
        book("mod13", 1, 32'd200, 1'b1, 32'd58, 1'b1);

        // Unsigned full-width price compares
        cmd(0, OP_ADD, 1'b1, 0, 64'd40, 32'hFFFF_FFF0, 32'd1, STAT_OK, 7, "u40");
        cmd(0, OP_ADD, 1'b1, 0, 64'd41, 32'h7FFF_FFFF, 32'd1, STAT_OK, 7, "u41");
        cmd(0, OP_ADD, 1'b0, 0, 64'd42, 32'h8000_0000, 32'd1, STAT_OK, 7, "u42");
        cmd(0, OP_ADD, 1'b0, 0, 64'd43, 32'd5,         32'd1, STAT_OK, 7, "u43");
        book("unsigned", 0, 32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 1'b1);
        cmd(0, OP_DEL, 1'b0, 0, 64'd41, 32'd0, 32'd0, STAT_OK, 7, "del41");
        book("del41", 0, 32'h8000_0000, 1'b1, 32'hFFFF_FFF0, 1'b1);

        // Reset during SCAN aborts without a response
        @(negedge clk);
        bus.in_valid = 1'b1;  bus.in_op = OP_ADD;  bus.in_side = 1'b0;
        bus.in_stock = 1'b0;  bus.in_ref_id = 64'd50;
        bus.in_price = 32'd77;  bus.in_qty = 32'd1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("arst/rsp_valid",  bus.rsp_valid, 1'b0);
        chk("arst/in_ready",   bus.in_ready, 1'b1);
        chk("arst/rsp_status", bus.rsp_status, STAT_OK);
        chk("arst/bid_all",    bus.best_bid_price, '0);
        chk("arst/ask_all",    bus.best_ask_price, '0);
        chk("arst/vld_all",    {bus.best_bid_vld, bus.best_ask_vld}, '0);
        saw_rsp = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) saw_rsp = 1'b1;
            if (k == 2) reset_n = 1'b1;
        end
        chk("arst/no_rsp", saw_rsp, 1'b0);
        cmd(0, OP_ADD, 1'b0, 0, 64'd1, 32'd40, 32'd1, STAT_OK, 7, "post_rst");
        book("post_rst/s0", 0, 32'd40, 1'b1, 32'd0, 1'b0);
        book("post_rst/s1", 1, 32'd0,  1'b0, 32'd0, 1'b0);
        cmd(0, OP_ADD, 1'b0, 1, 64'd10, 32'd7, 32'd1, STAT_OK, 7, "post_rst_id");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
